// File: rtl/bomb_code_arm.sv
// Code-entry front end for the bomb game: 4-word code entered, re-entered, then locked and armed.
// Enter releases are synchronized and debounced; the FSM acts DEBOUNCE_CYCLES+3 cycles after a release edge.
module bomb_code_arm #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [1:0] word_in,
  input  logic       enter_n,
  input  logic       disarm,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       arm_pulse,
  output logic [1:0] state,
  output logic [2:0] idx,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTER   = 2'd1,
    S_CONFIRM = 2'd2,
    S_ARMED   = 2'd3
  } state_e;

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      word_s1_q, word_s2_q;
  logic            en_s1_q, en_s2_q;
  logic            db_q, db_d;
  logic            db_prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ev_q, ev_d;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0][1:0] slot_q, slot_d;
  logic            err_q, err_d;
  logic            mism_q, mism_d;
  logic            arm_pulse_q, arm_pulse_d;
  logic            code_valid_q, code_valid_d;
  logic            mism_next;

  // Debounced level moves only after the synchronized key has disagreed with it
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (en_s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = en_s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign ev_d = db_q & ~db_prev_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    slot_d       = slot_q;
    err_d        = err_q;
    mism_d       = mism_q;
    arm_pulse_d  = 1'b0;
    code_valid_d = code_valid_q;
    mism_next    = mism_q | (word_s2_q != slot_q[idx_q[1:0]]);

    if (disarm) begin
      state_d      = S_IDLE;
      idx_d        = 3'd0;
      slot_d       = '0;
      err_d        = 1'b0;
      mism_d       = 1'b0;
      code_valid_d = 1'b0;
    end else if (ev_q) begin
      unique case (state_q)
        S_IDLE: begin
          slot_d[0] = word_s2_q;
          idx_d     = 3'd1;
          err_d     = 1'b0;
          state_d   = S_ENTER;
        end
        S_ENTER: begin
          slot_d[idx_q[1:0]] = word_s2_q;
          err_d              = 1'b0;
          if (idx_q == 3'd3) begin
            idx_d   = 3'd0;
            mism_d  = 1'b0;
            state_d = S_CONFIRM;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        S_CONFIRM: begin
          if (idx_q == 3'd3) begin
            mism_d = 1'b0;
            if (!mism_next) begin
              idx_d        = 3'd4;
              state_d      = S_ARMED;
              code_valid_d = 1'b1;
              arm_pulse_d  = 1'b1;
            end else begin
              // Failed confirmation: start the whole code over, flagging the error.
              idx_d   = 3'd0;
              slot_d  = '0;
              err_d   = 1'b1;
              state_d = S_ENTER;
            end
          end else begin
            mism_d = mism_next;
            idx_d  = idx_q + 3'd1;
          end
        end
        S_ARMED: begin
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      word_s1_q    <= 2'd0;
      word_s2_q    <= 2'd0;
      en_s1_q      <= 1'b1;
      en_s2_q      <= 1'b1;
      db_q         <= 1'b1;
      db_prev_q    <= 1'b1;
      cnt_q        <= '0;
      ev_q         <= 1'b0;
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      slot_q       <= '0;
      err_q        <= 1'b0;
      mism_q       <= 1'b0;
      arm_pulse_q  <= 1'b0;
      code_valid_q <= 1'b0;
    end else begin
      word_s1_q    <= word_in;
      word_s2_q    <= word_s1_q;
      en_s1_q      <= enter_n;
      en_s2_q      <= en_s1_q;
      db_q         <= db_d;
      db_prev_q    <= db_q;
      cnt_q        <= cnt_d;
      ev_q         <= ev_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      slot_q       <= slot_d;
      err_q        <= err_d;
      mism_q       <= mism_d;
      arm_pulse_q  <= arm_pulse_d;
      code_valid_q <= code_valid_d;
    end
  end

  assign code       = slot_q;
  assign code_valid = code_valid_q;
  assign arm_pulse  = arm_pulse_q;
  assign state      = state_q;
  assign idx        = idx_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bomb_code_arm.sv
// Directed bench for bomb_code_arm with DEBOUNCE_CYCLES=4: table of key releases plus
// hand sequences for glitches, bounce, disarm/ev collisions and mid-entry reset.
module tb_bomb_code_arm;
  localparam int D = 4;

  logic       CLOCK_50 = 1'b0;
  logic       rst;
  logic [1:0] word_in;
  logic       enter_n;
  logic       disarm;
  logic [7:0] code;
  logic       code_valid;
  logic       arm_pulse;
  logic [1:0] state;
  logic [2:0] idx;
  logic       err;

  bomb_code_arm #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .word_in   (word_in),
    .enter_n   (enter_n),
    .disarm    (disarm),
    .code      (code),
    .code_valid(code_valid),
    .arm_pulse (arm_pulse),
    .state     (state),
    .idx       (idx),
    .err       (err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [1:0] w;
    logic [1:0] st;
    logic [2:0] ix;
    logic [7:0] cd;
    logic       er;
    logic       cv;
    logic       ap;
  } row_t;

  row_t       rows [34];
  int         checks = 0;
  int         failures = 0;
  int         arm_cnt = 0;
  int         arm_bad = 0;
  logic       cv_prev = 1'b0;
  logic [1:0] cur_st;
  logic [2:0] cur_ix;

  // arm_pulse must coincide with the rise of code_valid
  always @(negedge CLOCK_50) begin
    if (arm_pulse) arm_cnt++;
    if (arm_pulse && !code_valid) arm_bad++;
    if (code_valid && !cv_prev && !arm_pulse) arm_bad++;
    cv_prev = code_valid;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [1:0] w);
    @(negedge CLOCK_50);
    word_in = w;
    enter_n = 1'b0;
    repeat (D + 6) @(negedge CLOCK_50);
  endtask

  task automatic run_row(input int i);
    press(rows[i].w);
    enter_n = 1'b1;
    repeat (D + 3) @(negedge CLOCK_50);
    check($sformatf("r%0d_pre_state", i), state, cur_st);
    check($sformatf("r%0d_pre_idx", i), idx, cur_ix);
    @(negedge CLOCK_50);
    check($sformatf("r%0d_state", i), state, rows[i].st);
    check($sformatf("r%0d_idx", i), idx, rows[i].ix);
    check($sformatf("r%0d_code", i), code, rows[i].cd);
    check($sformatf("r%0d_err", i), err, rows[i].er);
    check($sformatf("r%0d_code_valid", i), code_valid, rows[i].cv);
    check($sformatf("r%0d_arm_pulse", i), arm_pulse, rows[i].ap);
    cur_st = rows[i].st;
    cur_ix = rows[i].ix;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_row(i);
  endtask

  // Release with disarm asserted exactly in the cycle ev is presented to the FSM.
  task automatic release_with_disarm(input logic [1:0] w, input string tag);
    press(w);
    enter_n = 1'b1;
    repeat (D + 3) @(negedge CLOCK_50);
    disarm = 1'b1;
    @(negedge CLOCK_50);
    disarm = 1'b0;
    check({tag, "_state"}, state, 2'd0);
    check({tag, "_idx"}, idx, 3'd0);
    check({tag, "_code"}, code, 8'h00);
    check({tag, "_code_valid"}, code_valid, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    repeat (10) @(negedge CLOCK_50);
    check({tag, "_dropped_state"}, state, 2'd0);
    check({tag, "_dropped_idx"}, idx, 3'd0);
  endtask

  initial begin
    // enter 0,1,3,2 then confirm it
    rows[0]  = '{2'd0, 2'd1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0};
    rows[1]  = '{2'd1, 2'd1, 3'd2, 8'h04, 1'b0, 1'b0, 1'b0};
    rows[2]  = '{2'd3, 2'd1, 3'd3, 8'h34, 1'b0, 1'b0, 1'b0};
    rows[3]  = '{2'd2, 2'd2, 3'd0, 8'hB4, 1'b0, 1'b0, 1'b0};
    rows[4]  = '{2'd0, 2'd2, 3'd1, 8'hB4, 1'b0, 1'b0, 1'b0};
    rows[5]  = '{2'd1, 2'd2, 3'd2, 8'hB4, 1'b0, 1'b0, 1'b0};
    rows[6]  = '{2'd3, 2'd2, 3'd3, 8'hB4, 1'b0, 1'b0, 1'b0};
    rows[7]  = '{2'd2, 2'd3, 3'd4, 8'hB4, 1'b0, 1'b1, 1'b1};
    // releases while armed change nothing
    rows[8]  = '{2'd1, 2'd3, 3'd4, 8'hB4, 1'b0, 1'b1, 1'b0};
    rows[9]  = '{2'd2, 2'd3, 3'd4, 8'hB4, 1'b0, 1'b1, 1'b0};
    rows[10] = '{2'd3, 2'd3, 3'd4, 8'hB4, 1'b0, 1'b1, 1'b0};
    rows[11] = '{2'd0, 2'd3, 3'd4, 8'hB4, 1'b0, 1'b1, 1'b0};
    rows[12] = '{2'd2, 2'd3, 3'd4, 8'hB4, 1'b0, 1'b1, 1'b0};
    // enter 0,1,3,2, confirm 0,1,2,2 -> mismatch, then err cleared by next word
    rows[13] = '{2'd0, 2'd1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0};
    rows[14] = '{2'd1, 2'd1, 3'd2, 8'h04, 1'b0, 1'b0, 1'b0};
    rows[15] = '{2'd3, 2'd1, 3'd3, 8'h34, 1'b0, 1'b0, 1'b0};
    rows[16] = '{2'd2, 2'd2, 3'd0, 8'hB4, 1'b0, 1'b0, 1'b0};
    rows[17] = '{2'd0, 2'd2, 3'd1, 8'hB4, 1'b0, 1'b0, 1'b0};
    rows[18] = '{2'd1, 2'd2, 3'd2, 8'hB4, 1'b0, 1'b0, 1'b0};
    rows[19] = '{2'd2, 2'd2, 3'd3, 8'hB4, 1'b0, 1'b0, 1'b0};
    rows[20] = '{2'd2, 2'd1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0};
    rows[21] = '{2'd3, 2'd1, 3'd1, 8'h03, 1'b0, 1'b0, 1'b0};
    // finish entry 3,2,1,0 and two confirm words before reset
    rows[22] = '{2'd1, 2'd1, 3'd3, 8'h1B, 1'b0, 1'b0, 1'b0};
    rows[23] = '{2'd0, 2'd2, 3'd0, 8'h1B, 1'b0, 1'b0, 1'b0};
    rows[24] = '{2'd3, 2'd2, 3'd1, 8'h1B, 1'b0, 1'b0, 1'b0};
    rows[25] = '{2'd2, 2'd2, 3'd2, 8'h1B, 1'b0, 1'b0, 1'b0};
    // after reset: full enter + confirm of 3,2,1,0
    rows[26] = '{2'd3, 2'd1, 3'd1, 8'h03, 1'b0, 1'b0, 1'b0};
    rows[27] = '{2'd2, 2'd1, 3'd2, 8'h0B, 1'b0, 1'b0, 1'b0};
    rows[28] = '{2'd1, 2'd1, 3'd3, 8'h1B, 1'b0, 1'b0, 1'b0};
    rows[29] = '{2'd0, 2'd2, 3'd0, 8'h1B, 1'b0, 1'b0, 1'b0};
    rows[30] = '{2'd3, 2'd2, 3'd1, 8'h1B, 1'b0, 1'b0, 1'b0};
    rows[31] = '{2'd2, 2'd2, 3'd2, 8'h1B, 1'b0, 1'b0, 1'b0};
    rows[32] = '{2'd1, 2'd2, 3'd3, 8'h1B, 1'b0, 1'b0, 1'b0};
    rows[33] = '{2'd0, 2'd3, 3'd4, 8'h1B, 1'b0, 1'b1, 1'b1};

    rst     = 1'b1;
    word_in = 2'd0;
    enter_n = 1'b1;
    disarm  = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    rst = 1'b0;
    @(negedge CLOCK_50);
    check("reset_state", state, 2'd0);
    check("reset_idx", idx, 3'd0);
    check("reset_code", code, 8'h00);
    check("reset_code_valid", code_valid, 1'b0);
    check("reset_arm_pulse", arm_pulse, 1'b0);
    check("reset_err", err, 1'b0);
    cur_st = 2'd0;
    cur_ix = 3'd0;

    run_rows(0, 7);
    check("arm_pulse_once", arm_cnt, 1);
    run_rows(8, 12);
    check("armed_no_rearm", arm_cnt, 1);

    release_with_disarm(2'd1, "disarm_armed");
    release_with_disarm(2'd2, "disarm_idle");
    cur_st = 2'd0;
    cur_ix = 3'd0;

    run_rows(13, 21);

    // 3-cycle low glitch on the key: no event
    @(negedge CLOCK_50);
    enter_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    enter_n = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    check("glitch_state", state, 2'd1);
    check("glitch_idx", idx, 3'd1);

    // bouncing release: exactly one event, timed from the final stable edge
    press(2'd2);
    enter_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    enter_n = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    enter_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    enter_n = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    enter_n = 1'b1;
    repeat (D + 3) @(negedge CLOCK_50);
    check("bounce_pre_idx", idx, 3'd1);
    @(negedge CLOCK_50);
    check("bounce_idx", idx, 3'd2);
    check("bounce_code", code, 8'h0B);
    repeat (20) @(negedge CLOCK_50);
    check("bounce_single_idx", idx, 3'd2);
    check("bounce_single_state", state, 2'd1);
    cur_st = 2'd1;
    cur_ix = 3'd2;

    run_rows(22, 25);

    rst = 1'b1;
    @(negedge CLOCK_50);
    rst = 1'b0;
    check("midrst_state", state, 2'd0);
    check("midrst_idx", idx, 3'd0);
    check("midrst_code", code, 8'h00);
    check("midrst_err", err, 1'b0);
    check("midrst_code_valid", code_valid, 1'b0);
    repeat (4) @(negedge CLOCK_50);
    cur_st = 2'd0;
    cur_ix = 3'd0;

    run_rows(26, 33);
    check("arm_pulse_total", arm_cnt, 2);
    check("arm_pulse_with_valid", arm_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
